vga_sync_monitor: RTL and testbench
===================================

Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA sync generator.
- Samples hsync/vsync, rebuilds the pixel x/y coordinates and the active-video flag, and measures line and frame lengths.
- Checks those lengths against the programmed timing and runs a lock state machine.
- Used as a self-check on the generator's output in benches and as a timing recoverer for a downstream pixel checker.

Parameters:
- H_TOTAL, 800, pixel clocks per line
- H_SYNC, 96, hsync pulse width in clocks
- H_BACK, 48, back porch in clocks, counted from the end of hsync
- H_ACTIVE, 640, visible pixels per line
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, vertical back porch in lines
- V_ACTIVE, 480, visible lines
- SYNC_ACTIVE_LOW, 1, 1 = hs/vs asserted low; 0 = asserted high
- LOCK_FRAMES, 2, consecutive good frames required to reach LOCKED

Ports:
- clock  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- hs  in  1  horizontal sync from the generator
- vs  in  1  vertical sync from the generator
- x  out  10  active-area column, 0..H_ACTIVE-1; 0 outside the active area
- y  out  10  active-area row, 0..V_ACTIVE-1; 0 outside the active area
- active  out  1  1 when the current pixel is visible and lock=1
- lock  out  1  1 in the LOCKED state
- line_err  out  1  one-cycle pulse on a bad line length or a missing hsync
- frame_err  out  1  one-cycle pulse on a bad frame length or a missing vsync
- line_len  out  12  last measured line length in clocks
- frame_len  out  12  last measured frame length in lines

Behaviour:
- Reset (async, active-high): all outputs 0, counters 0, sync sample registers hold the deasserted level, FSM=UNLOCKED.
- Sampling:
  - hs/vs are registered once (s_hs, s_vs), then once more (p_hs, p_vs).
  - Polarity is normalised by SYNC_ACTIVE_LOW.
  - h_edge = s_hs asserted AND p_hs deasserted; v_edge is defined the same way on vs.
- Horizontal counter hcnt (12 bits):
  - On h_edge: line_len <= hcnt+1, then hcnt <= 0.
  - Otherwise hcnt increments, saturating at 4095.
- Vertical counter vcnt (12 bits):
  - On v_edge: frame_len <= vcnt + h_edge, then vcnt <= 0 (vsync wins over a coincident h_edge).
  - Else on h_edge: vcnt increments, saturating at 4095.
- Active window:
  - hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE)
  - AND vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE)
  - AND lock.
- x/y/active registered:
  - x = hcnt-(H_SYNC+H_BACK), y = vcnt-(V_SYNC+V_BACK) when inside the window.
  - x = y = active = 0 outside it.
- Latency: hs first sampled asserted at clock edge k -> hcnt=0 after edge k+2 -> x/active reflect it after edge k+3.
- Errors (checks only in CHECK and LOCKED; never flagged in UNLOCKED):
  - line_err: h_edge with line_len != H_TOTAL, OR hcnt reaching 2*H_TOTAL with no h_edge (pulse once per timeout, not every cycle).
  - frame_err: v_edge with frame_len != V_TOTAL, OR vcnt reaching 2*V_TOTAL with no v_edge.
  - line_len and frame_len always update, including in UNLOCKED.
- FSM:
  - UNLOCKED: on v_edge -> CHECK, good=0.
  - CHECK:
    - line_err or frame_err -> UNLOCKED.
    - v_edge with no error in that frame -> good+1.
    - When good reaches LOCK_FRAMES -> LOCKED, lock=1 on the same edge.
  - LOCKED: any line_err/frame_err -> UNLOCKED, lock=0 in the same cycle the err pulse is high.
- Simultaneous h_edge and v_edge: both line and frame checks run; both errors may pulse in the same cycle.
- Reset mid-frame: immediate return to the reset state; the first partial line/frame after release is never flagged.

Test Plan:
- Nominal 640x480 stream, active-low syncs -> no err pulses; lock rises at the v_edge ending the 2nd full frame after the first v_edge; line_len=800, frame_len=525.
- Locked, sample hcnt=144 on line vcnt=35 -> x=0, y=0, active=1 three clocks after the pixel; hcnt=783, vcnt=514 -> x=639, y=479; hcnt=784 -> active=0, x=0.
- Locked, one line shortened to 799 clocks -> line_err single pulse at that h_edge, lock=0 the same cycle, line_len=799; relock after 2 further good frames.
- Locked, hs held deasserted -> line_err pulse exactly once, when hcnt reaches 1600; lock drops; no repeated pulses while hs stays stuck.
- Frame with 524 lines -> frame_err pulse at v_edge, frame_len=524; with SYNC_ACTIVE_LOW=0 and inverted stimulus, the nominal case locks identically.
- Assert reset mid-frame while locked -> all outputs 0 asynchronously; after release, the partial frame produces no err; lock is regained after 2 good frames.

Source files
------------

// File: rtl/vga_sync_monitor.sv
// rtl/vga_sync_monitor.sv - VGA sync monitor: rebuilds pixel timing from hs/vs, measures and checks it, tracks lock
//
// Ports:
//   clock      in   pixel clock
//   reset      in   asynchronous, active-high reset
//   hs, vs     in   horizontal / vertical sync from the generator
//   x, y       out  active-area column / row, 0 outside the active area
//   active     out  current pixel visible and monitor locked
//   lock       out  LOCKED state
//   line_err   out  one-cycle pulse: bad line length or missing hsync
//   frame_err  out  one-cycle pulse: bad frame length or missing vsync
//   line_len   out  last measured line length in clocks
//   frame_len  out  last measured frame length in lines

module vga_sync_monitor #(
    parameter int H_TOTAL         = 800,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int H_ACTIVE        = 640,
    parameter int V_TOTAL         = 525,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int V_ACTIVE        = 480,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hs,
    input  logic        vs,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        active,
    output logic        lock,
    output logic        line_err,
    output logic        frame_err,
    output logic [11:0] line_len,
    output logic [11:0] frame_len
);

    localparam logic        ACT_LOW    = (SYNC_ACTIVE_LOW != 0);
    localparam logic [11:0] H_START    = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] H_END      = 12'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [11:0] V_START    = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] V_END      = 12'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [11:0] H_TOT      = 12'(H_TOTAL);
    localparam logic [11:0] V_TOT      = 12'(V_TOTAL);
    // Counter value one step before the missing-sync timeout is reached.
    localparam logic [11:0] H_TMO_LAST = 12'(2 * H_TOTAL - 1);
    localparam logic [11:0] V_TMO_LAST = 12'(2 * V_TOTAL - 1);
    localparam logic [11:0] CNT_SAT    = 12'hFFF;
    localparam logic [7:0]  GOOD_LOCK  = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_CHECK,
        ST_LOCKED
    } state_t;

    // Sync samples are kept normalised: 1 = asserted, so reset (0) is the deasserted level.
    logic        s_hs_q, p_hs_q, s_vs_q, p_vs_q;
    logic        h_edge_q, v_edge_q;
    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] vcnt_q, vcnt_d;
    logic [11:0] line_len_q, line_len_d;
    logic [11:0] frame_len_q, frame_len_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        active_q, active_d;
    state_t      state_q, state_d;
    logic [7:0]  good_q, good_d;

    logic        checking;
    logic        in_win;
    logic [11:0] line_meas;
    logic [11:0] frame_meas;
    logic [7:0]  good_inc;

    // The edge pulse is registered so the counters restart two clocks after
    // the first asserted sample, giving x/active a three-clock latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_hs_q      <= 1'b0;
            p_hs_q      <= 1'b0;
            s_vs_q      <= 1'b0;
            p_vs_q      <= 1'b0;
            h_edge_q    <= 1'b0;
            v_edge_q    <= 1'b0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            line_len_q  <= '0;
            frame_len_q <= '0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            active_q    <= 1'b0;
            state_q     <= ST_UNLOCKED;
            good_q      <= '0;
        end else begin
            s_hs_q      <= hs ^ ACT_LOW;
            p_hs_q      <= s_hs_q;
            s_vs_q      <= vs ^ ACT_LOW;
            p_vs_q      <= s_vs_q;
            h_edge_q    <= s_hs_q & ~p_hs_q;
            v_edge_q    <= s_vs_q & ~p_vs_q;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            line_len_q  <= line_len_d;
            frame_len_q <= frame_len_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            x_q         <= x_d;
            y_q         <= y_d;
            active_q    <= active_d;
            state_q     <= state_d;
            good_q      <= good_d;
        end
    end

    always_comb begin
        checking    = (state_q != ST_UNLOCKED);
        line_meas   = hcnt_q + 12'd1;
        // A line start coinciding with vsync closes the frame's last line.
        frame_meas  = vcnt_q + {11'd0, h_edge_q};

        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        line_len_d  = line_len_q;
        frame_len_d = frame_len_q;

        if (h_edge_q) begin
            hcnt_d     = '0;
            line_len_d = line_meas;
        end else if (hcnt_q != CNT_SAT) begin
            hcnt_d = hcnt_q + 12'd1;
        end

        if (v_edge_q) begin
            vcnt_d      = '0;
            frame_len_d = frame_meas;
        end else if (h_edge_q && (vcnt_q != CNT_SAT)) begin
            vcnt_d = vcnt_q + 12'd1;
        end

        // Timeouts fire on the single step onto 2*TOTAL; the counter then moves
        // past it (or saturates) so a stuck sync pulses only once.
        line_err_d  = checking &&
                      ((h_edge_q && (line_meas != H_TOT)) ||
                       (!h_edge_q && (hcnt_q == H_TMO_LAST)));
        frame_err_d = checking &&
                      ((v_edge_q && (frame_meas != V_TOT)) ||
                       (!v_edge_q && h_edge_q && (vcnt_q == V_TMO_LAST)));
    end

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        good_inc = good_q + 8'd1;
        case (state_q)
            ST_UNLOCKED: begin
                if (v_edge_q) begin
                    state_d = ST_CHECK;
                    good_d  = '0;
                end
            end
            ST_CHECK: begin
                if (line_err_d || frame_err_d) begin
                    state_d = ST_UNLOCKED;
                end else if (v_edge_q) begin
                    good_d = good_inc;
                    if (good_inc == GOOD_LOCK) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (line_err_d || frame_err_d) begin
                    state_d = ST_UNLOCKED;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
            end
        endcase
    end

    always_comb begin
        in_win   = (hcnt_q >= H_START) && (hcnt_q < H_END) &&
                   (vcnt_q >= V_START) && (vcnt_q < V_END) &&
                   (state_q == ST_LOCKED);
        x_d      = '0;
        y_d      = '0;
        active_d = in_win;
        if (in_win) begin
            x_d = 10'(hcnt_q - H_START);
            y_d = 10'(vcnt_q - V_START);
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign active    = active_q;
    assign lock      = (state_q == ST_LOCKED);
    assign line_err  = line_err_q;
    assign frame_err = frame_err_q;
    assign line_len  = line_len_q;
    assign frame_len = frame_len_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb/tb_vga_sync_monitor.sv - directed self-checking bench for vga_sync_monitor with a reduced-size timing

module tb_vga_sync_monitor;

    localparam int H_T = 20;
    localparam int HS  = 3;
    localparam int HB  = 2;
    localparam int HA  = 12;
    localparam int V_T = 12;
    localparam int VS  = 2;
    localparam int VB  = 2;
    localparam int VA  = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        hs = 1'b1, vs = 1'b1;
    logic        hs_b = 1'b0, vs_b = 1'b0;
    logic [9:0]  x, y, x_b, y_b;
    logic        active, lock, line_err, frame_err;
    logic        active_b, lock_b, line_err_b, frame_err_b;
    logic [11:0] line_len, frame_len, line_len_b, frame_len_b;

    int errors = 0;
    int checks = 0;

    vga_sync_monitor #(
        .H_TOTAL(H_T), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
        .V_TOTAL(V_T), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
        .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
    ) dut (
        .clock(clock), .reset(reset), .hs(hs), .vs(vs),
        .x(x), .y(y), .active(active), .lock(lock),
        .line_err(line_err), .frame_err(frame_err),
        .line_len(line_len), .frame_len(frame_len)
    );

    vga_sync_monitor #(
        .H_TOTAL(H_T), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
        .V_TOTAL(V_T), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
        .SYNC_ACTIVE_LOW(0), .LOCK_FRAMES(2)
    ) dut_b (
        .clock(clock), .reset(reset), .hs(hs_b), .vs(vs_b),
        .x(x_b), .y(y_b), .active(active_b), .lock(lock_b),
        .line_err(line_err_b), .frame_err(frame_err_b),
        .line_len(line_len_b), .frame_len(frame_len_b)
    );

    always #5 clock = ~clock;

    // Sync generator: drives one pixel per falling edge; hist[i] is the pixel driven i falling edges ago.
    int gh, gv, la, cur_hlen, cur_vlen, stuck_la;
    bit shorten_line_req = 0, shorten_frame_req = 0, stuck_req = 0, unstick_req = 0, stuck = 0;
    int hist_h[5], hist_v[5], hist_l[5];

    initial begin
        gh = 7; gv = 5; la = 0; cur_hlen = H_T; cur_vlen = V_T; stuck_la = -1;
        for (int i = 0; i < 5; i++) begin
            hist_h[i] = -1; hist_v[i] = -1; hist_l[i] = -1;
        end
        forever begin
            @(negedge clock);
            if (gh == 0) begin
                if (stuck_req && gv == 3) begin
                    stuck = 1; stuck_req = 0; stuck_la = la;
                end
                if (unstick_req) begin
                    stuck = 0; unstick_req = 0;
                end
                cur_hlen = H_T;
                if (shorten_line_req && gv == 5) begin
                    cur_hlen = H_T - 1; shorten_line_req = 0;
                end
                if (gv == 0) begin
                    cur_vlen = V_T;
                    if (shorten_frame_req) begin
                        cur_vlen = V_T - 1; shorten_frame_req = 0;
                    end
                end
            end
            for (int i = 4; i > 0; i--) begin
                hist_h[i] = hist_h[i-1]; hist_v[i] = hist_v[i-1]; hist_l[i] = hist_l[i-1];
            end
            hist_h[0] = gh; hist_v[0] = gv; hist_l[0] = la;
            hs   = stuck ? 1'b1 : ((gh < HS) ? 1'b0 : 1'b1);
            vs   = (gv < VS) ? 1'b0 : 1'b1;
            hs_b = ~hs;
            vs_b = ~vs;
            gh++;
            if (gh >= cur_hlen) begin
                gh = 0; la++; gv++;
                if (gv >= cur_vlen) gv = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic run_until_lock(input int max, output bit ok, output bit at_fs,
                                  output int frames, output int lerr, output int ferr, output int lmis);
        ok = 0; at_fs = 0; frames = 0; lerr = 0; ferr = 0; lmis = 0;
        for (int c = 0; c < max; c++) begin
            step();
            if (line_err) lerr++;
            if (frame_err) ferr++;
            if (lock_b !== lock) lmis++;
            if (hist_h[3] == 0 && hist_v[3] == 0) frames++;
            if (lock) begin
                ok = 1;
                at_fs = (hist_h[3] == 0 && hist_v[3] == 0);
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({x, y} !== 20'd0) begin
            errors++; $display("FAIL reset_xy: x=%0d y=%0d, want 0 0", x, y);
        end
        checks++;
        if ({active, lock, line_err, frame_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: act/lock/lerr/ferr=%b, want 0000", {active, lock, line_err, frame_err});
        end
        checks++;
        if ({line_len, frame_len} !== 24'd0) begin
            errors++; $display("FAIL reset_len: line_len=%0d frame_len=%0d, want 0 0", line_len, frame_len);
        end
    endtask

    task automatic test_nominal();
        bit ok, at_fs;
        int frames, lerr, ferr, lmis;
        #1 reset = 1'b0;
        run_until_lock(2000, ok, at_fs, frames, lerr, ferr, lmis);
        checks++;
        if (!ok || !at_fs || frames != 3) begin
            errors++; $display("FAIL nominal_lock: ok=%0d at_frame_start=%0d frames=%0d, want 1 1 3", ok, at_fs, frames);
        end
        checks++;
        if (lerr != 0 || ferr != 0) begin
            errors++; $display("FAIL nominal_errs: line_err=%0d frame_err=%0d, want 0 0", lerr, ferr);
        end
        checks++;
        if (line_len !== 12'(H_T) || frame_len !== 12'(V_T)) begin
            errors++; $display("FAIL nominal_len: line_len=%0d frame_len=%0d, want %0d %0d", line_len, frame_len, H_T, V_T);
        end
        checks++;
        if (lmis != 0 || lock_b !== 1'b1 || line_len_b !== 12'(H_T) || frame_len_b !== 12'(V_T)) begin
            errors++; $display("FAIL polarity_high: lock mismatches=%0d lock_b=%0d line_len_b=%0d frame_len_b=%0d, want 0 1 %0d %0d",
                               lmis, lock_b, line_len_b, frame_len_b, H_T, V_T);
        end
    endtask

    task automatic test_locked_frame();
        int act_cnt = 0, err_cnt = 0, unl_cnt = 0;
        for (int c = 0; c < H_T * V_T; c++) begin
            step();
            if (active) act_cnt++;
            if (line_err || frame_err) err_cnt++;
            if (!lock) unl_cnt++;
        end
        checks++;
        if (act_cnt != HA * VA) begin
            errors++; $display("FAIL frame_active_count: got %0d, want %0d", act_cnt, HA * VA);
        end
        checks++;
        if (err_cnt != 0 || unl_cnt != 0) begin
            errors++; $display("FAIL frame_stable: err cycles=%0d unlocked cycles=%0d, want 0 0", err_cnt, unl_cnt);
        end
    endtask

    task automatic test_active_window();
        int ph[6] = '{HS + HB, HS + HB + HA - 1, HS + HB + HA, HS + HB, HS + HB - 1, HS + HB + 5};
        int pv[6] = '{VS + VB, VS + VB + VA - 1, VS + VB + VA - 1, VS + VB - 1, VS + VB, VS + VB + 2};
        int ex[6] = '{0, HA - 1, 0, 0, 0, 5};
        int ey[6] = '{0, VA - 1, 0, 0, 0, 2};
        bit ea[6] = '{1, 1, 0, 0, 0, 1};
        for (int p = 0; p < 6; p++) begin
            bit found = 0;
            for (int c = 0; c < 400 && !found; c++) begin
                step();
                if (hist_h[4] == ph[p] && hist_v[4] == pv[p]) found = 1;
            end
            checks++;
            if (!found || x !== 10'(ex[p]) || y !== 10'(ey[p]) || active !== ea[p]) begin
                errors++; $display("FAIL window_%0d_%0d: found=%0d x=%0d y=%0d active=%0d, want 1 %0d %0d %0d",
                                   ph[p], pv[p], found, x, y, active, ex[p], ey[p], ea[p]);
            end
        end
    endtask

    task automatic test_short_line();
        bit seen = 0, ok, at_fs;
        int frames, lerr, ferr, lmis;
        shorten_line_req = 1;
        for (int c = 0; c < 600 && !seen; c++) begin
            step();
            if (line_err) seen = 1;
        end
        checks++;
        if (!seen || hist_h[3] != 0 || hist_v[3] != 6) begin
            errors++; $display("FAIL short_line_pulse: seen=%0d at h=%0d v=%0d, want 1 0 6", seen, hist_h[3], hist_v[3]);
        end
        checks++;
        if (lock !== 1'b0 || line_len !== 12'(H_T - 1) || frame_err !== 1'b0) begin
            errors++; $display("FAIL short_line_state: lock=%0d line_len=%0d frame_err=%0d, want 0 %0d 0",
                               lock, line_len, frame_err, H_T - 1);
        end
        run_until_lock(2000, ok, at_fs, frames, lerr, ferr, lmis);
        checks++;
        if (!ok || !at_fs || frames != 3 || lerr != 0 || ferr != 0) begin
            errors++; $display("FAIL short_line_relock: ok=%0d at_fs=%0d frames=%0d lerr=%0d ferr=%0d, want 1 1 3 0 0",
                               ok, at_fs, frames, lerr, ferr);
        end
    endtask

    task automatic test_hs_stuck();
        bit seen = 0, ok, at_fs;
        int frames, lerr, ferr, lmis, extra = 0;
        stuck_req = 1;
        for (int c = 0; c < 600 && !seen; c++) begin
            step();
            if (line_err) seen = 1;
        end
        checks++;
        if (!seen || hist_l[3] != stuck_la + 1 || hist_h[3] != 0 || lock !== 1'b0) begin
            errors++; $display("FAIL stuck_timeout: seen=%0d line=%0d h=%0d lock=%0d, want 1 %0d 0 0",
                               seen, hist_l[3], hist_h[3], lock, stuck_la + 1);
        end
        for (int c = 0; c < 120; c++) begin
            step();
            if (line_err || frame_err || lock) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++; $display("FAIL stuck_repeat: extra err/lock cycles=%0d, want 0", extra);
        end
        unstick_req = 1;
        run_until_lock(2000, ok, at_fs, frames, lerr, ferr, lmis);
        checks++;
        if (!ok || !at_fs || lerr != 0 || ferr != 0) begin
            errors++; $display("FAIL stuck_relock: ok=%0d at_fs=%0d lerr=%0d ferr=%0d, want 1 1 0 0", ok, at_fs, lerr, ferr);
        end
    endtask

    task automatic test_short_frame();
        bit seen = 0, ok, at_fs;
        int frames, lerr, ferr, lmis;
        shorten_frame_req = 1;
        for (int c = 0; c < 800 && !seen; c++) begin
            step();
            if (frame_err) seen = 1;
        end
        checks++;
        if (!seen || hist_h[3] != 0 || hist_v[3] != 0 || frame_len !== 12'(V_T - 1)) begin
            errors++; $display("FAIL short_frame_pulse: seen=%0d h=%0d v=%0d frame_len=%0d, want 1 0 0 %0d",
                               seen, hist_h[3], hist_v[3], frame_len, V_T - 1);
        end
        checks++;
        if (lock !== 1'b0 || line_err !== 1'b0 || frame_err_b !== 1'b1) begin
            errors++; $display("FAIL short_frame_state: lock=%0d line_err=%0d frame_err_b=%0d, want 0 0 1",
                               lock, line_err, frame_err_b);
        end
        run_until_lock(2000, ok, at_fs, frames, lerr, ferr, lmis);
        checks++;
        if (!ok || !at_fs || frames != 3 || lerr != 0 || ferr != 0) begin
            errors++; $display("FAIL short_frame_relock: ok=%0d at_fs=%0d frames=%0d lerr=%0d ferr=%0d, want 1 1 3 0 0",
                               ok, at_fs, frames, lerr, ferr);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0, ok, at_fs;
        int frames, lerr, ferr, lmis;
        for (int c = 0; c < 400 && !found; c++) begin
            step();
            if (hist_h[4] == HS + HB + 3 && hist_v[4] == VS + VB + 1) found = 1;
        end
        checks++;
        if (!found || active !== 1'b1 || x !== 10'd3 || y !== 10'd1) begin
            errors++; $display("FAIL pre_reset_pixel: found=%0d active=%0d x=%0d y=%0d, want 1 1 3 1", found, active, x, y);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({x, y, active, lock, line_err, frame_err} !== 24'd0 || {line_len, frame_len} !== 24'd0 || lock_b !== 1'b0) begin
            errors++; $display("FAIL async_reset: x=%0d y=%0d act=%0d lock=%0d line_len=%0d frame_len=%0d lock_b=%0d, want all 0",
                               x, y, active, lock, line_len, frame_len, lock_b);
        end
        repeat (3) step();
        found = 0;
        for (int c = 0; c < 400 && !found; c++) begin
            step();
            if (hist_h[0] == 10 && hist_v[0] == 6) found = 1;
        end
        #1 reset = 1'b0;
        run_until_lock(2000, ok, at_fs, frames, lerr, ferr, lmis);
        checks++;
        if (!found || !ok || !at_fs || frames != 3 || lerr != 0 || ferr != 0) begin
            errors++; $display("FAIL reset_relock: found=%0d ok=%0d at_fs=%0d frames=%0d lerr=%0d ferr=%0d, want 1 1 1 3 0 0",
                               found, ok, at_fs, frames, lerr, ferr);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_locked_frame();
        test_active_window();
        test_short_line();
        test_hs_stuck();
        test_short_frame();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
